// File: rtl/inst_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_ram_loader
// Description : Writable instruction memory. A program is streamed in over a
//               valid/ready load port, and the write address increments
//               automatically. The core then fetches from the memory through
//               a registered read port with 1-cycle latency. Fetches that are
//               outside the resident program, or that occur while no program
//               is resident, return 0 (NOP).
// Ports       : Clk, Reset            - clock, synchronous active-high reset
//               LoadStart             - pulse that begins or restarts a load
//               LoadValid/LoadData/   - load word stream; LoadLast marks the
//               LoadLast/LoadReady      final word
//               FetchEn/InstAddress   - fetch request and address
//               InstOut               - fetched word, valid 1 cycle after
//                                       FetchEn
//               Busy/Done/ProgLen/    - load status and resident program
//               Overflow                length
// Revision    : 1.0 - initial release
// ============================================================================
module inst_ram_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadStart,
    input  logic         LoadValid,
    input  logic [W-1:0] LoadData,
    input  logic         LoadLast,
    output logic         LoadReady,
    input  logic         FetchEn,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut,
    output logic         Busy,
    output logic         Done,
    output logic [A:0]   ProgLen,
    output logic         Overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};

    state_t         state;
    logic [A-1:0]   wptr;
    logic [W-1:0]   mem [2**A];
    logic [W-1:0]   ram_q;
    logic           fetch_hit;
    logic           write_en;
    logic [A-1:0]   ram_addr;

    assign LoadReady = (state == LOAD);
    assign Busy      = (state == LOAD);

    // A restart in the same cycle as a handshake discards the word.
    assign write_en  = (state == LOAD) && LoadValid && !LoadStart;

    // One shared address port: the writer owns it during LOAD, and the fetch
    // side owns it otherwise. Fetches made during LOAD are forced to 0 below,
    // so the two users never compete for the port.
    assign ram_addr  = (state == LOAD) ? wptr : InstAddress;

    // Control FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wptr     <= '0;
            ProgLen  <= '0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else if (LoadStart) begin
            state    <= LOAD;
            wptr     <= '0;
            ProgLen  <= '0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else if (write_en) begin
            wptr    <= wptr + 1'b1;
            ProgLen <= ProgLen + 1'b1;
            if (LoadLast) begin
                state <= READY;
                Done  <= 1'b1;
            end else if (wptr == LAST_ADDR) begin
                // The array is full and no end marker was seen. Close the
                // load and flag that the program is truncated.
                state    <= READY;
                Done     <= 1'b1;
                Overflow <= 1'b1;
            end
        end
    end

    // Synchronous single-port array with a registered read; this is
    // inferable as block RAM. It has no reset.
    always_ff @(posedge Clk) begin
        if (write_en) begin
            mem[ram_addr] <= LoadData;
        end
        if (FetchEn) begin
            ram_q <= mem[ram_addr];
        end
    end

    // Qualifies the registered read data. The bound check against ProgLen
    // makes stale contents from an older or aborted load unreachable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_hit <= 1'b0;
        end else if (FetchEn) begin
            fetch_hit <= (state == READY) && ({1'b0, InstAddress} < ProgLen);
        end
    end

    assign InstOut = fetch_hit ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_inst_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_ram_loader
// Description : Self-checking bench for inst_ram_loader. It drives two
//               instances from shared inputs: the default depth (A=10) and a
//               small depth (A=3) that reaches overflow. Expected fetch
//               results for both instances are queued when each fetch is
//               issued. A monitor pops and compares each entry on the cycle
//               after the fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_valid, ld_last, fetch_en;
    logic [8:0]  ld_data;
    logic [9:0]  inst_addr;

    logic        m_ready, m_busy, m_done, m_ovf;
    logic [8:0]  m_inst;
    logic [10:0] m_len;
    logic        s_ready, s_busy, s_done, s_ovf;
    logic [8:0]  s_inst;
    logic [3:0]  s_len;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0] exp_m;
        logic [8:0] exp_s;
    } fetch_exp_t;
    fetch_exp_t sb[$];
    logic fetch_pend = 1'b0;

    always #5 clk = ~clk;

    inst_ram_loader #(.A(10), .W(9)) dut (
        .Clk(clk), .Reset(rst), .LoadStart(ld_start), .LoadValid(ld_valid),
        .LoadData(ld_data), .LoadLast(ld_last), .LoadReady(m_ready),
        .FetchEn(fetch_en), .InstAddress(inst_addr), .InstOut(m_inst),
        .Busy(m_busy), .Done(m_done), .ProgLen(m_len), .Overflow(m_ovf)
    );

    inst_ram_loader #(.A(3), .W(9)) dut_small (
        .Clk(clk), .Reset(rst), .LoadStart(ld_start), .LoadValid(ld_valid),
        .LoadData(ld_data), .LoadLast(ld_last), .LoadReady(s_ready),
        .FetchEn(fetch_en), .InstAddress(inst_addr[2:0]), .InstOut(s_inst),
        .Busy(s_busy), .Done(s_done), .ProgLen(s_len), .Overflow(s_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: InstOut is due on the cycle after FetchEn is sampled.
    always @(posedge clk) fetch_pend <= fetch_en;

    always @(negedge clk) begin
        if (fetch_pend) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                fetch_exp_t e;
                e = sb.pop_front();
                check("fetch_main", {23'd0, m_inst}, {23'd0, e.exp_m});
                check("fetch_small", {23'd0, s_inst}, {23'd0, e.exp_s});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // Presents one word. It waits (bounded) for LoadReady on the main
    // instance, then completes the handshake.
    task automatic send(input logic [8:0] d, input logic last);
        int n = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (!m_ready && n < 16) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, m_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [9:0] a, input logic [8:0] em, input logic [8:0] es);
        fetch_exp_t e;
        e.exp_m = em;
        e.exp_s = es;
        sb.push_back(e);
        fetch_en  = 1'b1;
        inst_addr = a;
        tick();
        fetch_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        fetch_en = 1'b0; ld_data = '0; inst_addr = '0;

        // Reset state
        do_reset();
        check("rst_ready", {31'd0, m_ready}, 32'd0);
        check("rst_busy", {31'd0, m_busy}, 32'd0);
        check("rst_done", {31'd0, m_done}, 32'd0);
        check("rst_len", {21'd0, m_len}, 32'd0);
        check("rst_ovf", {31'd0, m_ovf}, 32'd0);
        check("rst_inst", {23'd0, m_inst}, 32'd0);
        fetch(10'd0, 9'h000, 9'h000);

        // Basic load and fetch
        start();
        check("load_busy", {31'd0, m_busy}, 32'd1);
        check("load_ready", {31'd0, m_ready}, 32'd1);
        send(9'h080, 1'b0);
        send(9'h08A, 1'b0);
        send(9'h040, 1'b0);
        send(9'h0A9, 1'b1);
        check("basic_done", {31'd0, m_done}, 32'd1);
        check("basic_len", {21'd0, m_len}, 32'd4);
        check("basic_busy", {31'd0, m_busy}, 32'd0);
        check("basic_len_s", {28'd0, s_len}, 32'd4);
        fetch(10'd0, 9'h080, 9'h080);
        fetch(10'd1, 9'h08A, 9'h08A);
        fetch(10'd2, 9'h040, 9'h040);
        fetch(10'd3, 9'h0A9, 9'h0A9);
        fetch(10'd4, 9'h000, 9'h000);
        tick();

        // Gapped load: valid pattern 1,0,0,1,0,1
        start();
        ld_valid = 1'b1; ld_data = 9'h111; tick();
        ld_valid = 1'b0; ld_data = 9'h1EE; tick(); tick();
        ld_valid = 1'b1; ld_data = 9'h122; tick();
        ld_valid = 1'b0; ld_data = 9'h1EE; tick();
        ld_valid = 1'b1; ld_data = 9'h133; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("gap_len", {21'd0, m_len}, 32'd3);
        check("gap_done", {31'd0, m_done}, 32'd1);
        fetch(10'd0, 9'h111, 9'h111);
        fetch(10'd1, 9'h122, 9'h122);
        fetch(10'd2, 9'h133, 9'h133);
        fetch(10'd3, 9'h000, 9'h000);
        tick();

        // Overflow on the depth-8 instance
        do_reset();
        start();
        ld_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ld_data = 9'h101 + 9'(i);
            tick();
        end
        check("ovf_flag", {31'd0, s_ovf}, 32'd1);
        check("ovf_done", {31'd0, s_done}, 32'd1);
        check("ovf_len", {28'd0, s_len}, 32'd8);
        check("ovf_ready", {31'd0, s_ready}, 32'd0);
        check("ovf_busy", {31'd0, s_busy}, 32'd0);
        check("ovf_main_busy", {31'd0, m_busy}, 32'd1);
        check("ovf_main_flag", {31'd0, m_ovf}, 32'd0);
        ld_data = 9'h109;
        tick();
        ld_valid = 1'b0;
        check("ovf_len_9th", {28'd0, s_len}, 32'd8);
        check("ovf_main_len", {21'd0, m_len}, 32'd9);
        fetch(10'd7, 9'h000, 9'h108);
        fetch(10'd0, 9'h000, 9'h101);
        tick();

        // Reset mid-load
        do_reset();
        start();
        send(9'h0F0, 1'b0);
        send(9'h0F1, 1'b0);
        do_reset();
        check("mid_busy", {31'd0, m_busy}, 32'd0);
        check("mid_ready", {31'd0, m_ready}, 32'd0);
        check("mid_len", {21'd0, m_len}, 32'd0);
        check("mid_done", {31'd0, m_done}, 32'd0);
        fetch(10'd0, 9'h000, 9'h000);
        tick();

        // Reload shorter program
        start();
        for (int i = 0; i < 6; i++) send(9'h0A0 + 9'(i), (i == 5));
        check("reload6_len", {21'd0, m_len}, 32'd6);
        start();
        send(9'h1FF, 1'b0);
        send(9'h0DD, 1'b1);
        check("reload2_len", {21'd0, m_len}, 32'd2);
        fetch(10'd1, 9'h0DD, 9'h0DD);
        fetch(10'd3, 9'h000, 9'h000);
        fetch(10'd0, 9'h1FF, 9'h1FF);
        tick();

        // Restart coincident with a handshake
        start();
        send(9'h077, 1'b0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 9'h0BB;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        send(9'h0CC, 1'b1);
        check("restart_len", {21'd0, m_len}, 32'd1);
        fetch(10'd1, 9'h000, 9'h000);
        fetch(10'd0, 9'h0CC, 9'h0CC);
        tick();

        // Fetch hold: with FetchEn low, an address change must not alter InstOut
        inst_addr = 10'd1;
        tick();
        inst_addr = 10'd2;
        tick();
        check("hold_main", {23'd0, m_inst}, 32'h0CC);
        check("hold_small", {23'd0, s_inst}, 32'h0CC);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_ram_loader.md
Name: inst_ram_loader

Overview:
- Parametrised, writable instruction memory; successor to the fixed case-table instruction ROM.
- A program is streamed in word by word over a valid/ready load port with auto-incrementing write address. The fetch port then serves the core with a registered, 1-cycle-latency read.
- Sits between the bench/boot source and the fetch stage. Replaces hard-coded programs so new machine code needs no RTL edit.

Parameters:
- A, 10, instruction address width; depth = 2**A words
- W, 9, instruction word width

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- LoadStart  in  1  one-cycle pulse; begin (or restart) a program load
- LoadValid  in  1  LoadData holds a valid word
- LoadData  in  W  instruction word to write
- LoadLast  in  1  qualifies the final word of the program (sampled with the handshake)
- LoadReady  out  1  block accepts a load word this cycle
- FetchEn  in  1  fetch request; InstOut updates next cycle
- InstAddress  in  A  fetch address
- InstOut  out  W  fetched instruction (registered)
- Busy  out  1  load in progress
- Done  out  1  a complete program is resident
- ProgLen  out  A+1  number of words in the resident program
- Overflow  out  1  sticky; load hit depth without LoadLast

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state IDLE; LoadReady=0, InstOut=0, Busy=0, Done=0, ProgLen=0, Overflow=0. Memory array is not cleared.
- FSM states are IDLE, LOAD and READY.
- IDLE:
  - LoadStart -> LOAD.
  - Fetches return 0.
- LOAD:
  - On entry (and on any LoadStart): write pointer=0, ProgLen=0, Done=0, Overflow=0.
  - Outputs: Busy=1, LoadReady=1 (combinational from state).
  - Handshake = LoadValid & LoadReady. Each handshake writes mem[wptr]=LoadData, then wptr++ and ProgLen++.
  - Handshake with LoadLast=1 -> READY, Done=1 next cycle.
  - Handshake at wptr=2**A-1 with LoadLast=0 -> READY, Done=1, Overflow=1. No further words are accepted.
  - LoadValid=0 cycles are idle gaps; pointer and length hold.
  - LoadStart in the same cycle as a handshake: restart wins, the word is discarded, wptr=0.
- READY:
  - Busy=0, LoadReady=0.
  - LoadStart -> LOAD; the previous program is logically discarded.
- Fetch:
  - Valid only in READY. When FetchEn=1, InstOut <= mem[InstAddress] if InstAddress < ProgLen, else 0 (NOP).
  - FetchEn=1 in IDLE or LOAD: InstOut <= 0.
  - FetchEn=0: InstOut holds its value.
  - Latency is exactly 1 cycle from FetchEn/InstAddress to InstOut.
- ProgLen is A+1 bits so that a full 2**A-word program is representable.
- Reset mid-load returns to IDLE with ProgLen=0. Stale array contents are unreachable because the ProgLen bound forces 0 on fetch.
- The write and fetch ports never conflict, because fetch is only served in READY.
- Implementation is a single-port synchronous array with a registered output; it is inferable as block RAM.

Test Plan:
- Basic load and fetch: Reset, LoadStart, then 4 handshakes {0x080, 0x08A, 0x040, 0x0A9} with LoadLast on the 4th.
  - Required: Done=1, ProgLen=4, Busy=0.
  - Fetch addresses 0..4 one per cycle -> InstOut = 0x080, 0x08A, 0x040, 0x0A9, 0x000, each 1 cycle after request.
- Gapped load: LoadValid toggles 1,0,0,1,0,1 with LoadLast on the 3rd valid word.
  - Required: ProgLen=3, words stored at addresses 0..2 in order, no word duplicated or skipped.
- Overflow (A=3): 9 valid words, LoadLast never asserted.
  - Required: after the 8th handshake, READY, Overflow=1, ProgLen=8, LoadReady=0.
  - The 9th word is not written.
  - Fetch address 7 returns the 8th word.
- Reset mid-load: 2 words accepted, then Reset.
  - Required: state IDLE, ProgLen=0, Done=0.
  - Fetch of address 0 returns 0.
- Reload shorter program: load 6 words, then LoadStart and load 2 words {0x1FF, 0x0DD}.
  - Required: ProgLen=2.
  - Fetch address 1 returns 0x0DD; fetch address 3 returns 0.
- Restart priority and fetch hold:
  - LoadStart coincident with a handshake -> word dropped, next handshake lands at address 0.
  - In READY with FetchEn=0 and InstAddress changing -> InstOut unchanged.
